data_stack: RTL and testbench



---
 rtl/data_stack_pkg.sv | 27 ++
 rtl/data_stack_if.sv | 36 +++
 rtl/data_stack_ram.sv | 34 +++
 rtl/data_stack.sv | 144 ++++++++++++++
 tb/tb_data_stack.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/data_stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types and defaults for the data stack.
//   WIDTH_DEF / DEPTH_DEF : default word width and entry count
//   stack_op_t            : operation decoded from {push, pop}
//   occ_state_t           : occupancy state of the stack
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 16;

    // Encoding matches {push, pop} so decode is a plain cast.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } stack_op_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } occ_state_t;

endpackage

// File: rtl/data_stack_if.sv
// -----------------------------------------------------------------------------
// data_stack_if
// Operand-stack bus between the producers (immediate sign extender / ALU result
// mux plus control) and the data stack.
//   push, pop, push_data, clear_err : requests into the stack (master drives)
//   tos, nos, count, empty, full     : stack contents/occupancy (slave drives)
//   overflow, underflow              : sticky error flags (slave drives)
// -----------------------------------------------------------------------------
interface data_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             clear_err;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, push_data, clear_err,
        input  tos, nos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, clear_err,
        output tos, nos, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/data_stack_ram.sv
// -----------------------------------------------------------------------------
// stack_ram
// Backing store for the stack entries below TOS and NOS (DEPTH-2 words).
//   clk   : write clock
//   we    : write enable; addresses beyond the array are ignored
//   waddr : write address,  wdata : write data
//   raddr : asynchronous read address, rdata : read data (0 when out of range)
// -----------------------------------------------------------------------------
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam logic [AW-1:0] NENT = AW'(DEPTH - 2);

    logic [WIDTH-1:0] mem [DEPTH-2];

    // Out-of-range writes only happen after a pointer wrap, whose contents
    // are don't-care, so they are simply dropped.
    always_ff @(posedge clk) begin
        if (we && (waddr < NENT))
            mem[waddr] <= wdata;
    end

    assign rdata = (raddr < NENT) ? mem[raddr] : '0;

endmodule

// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
// Operand stack for the stack processor. TOS and NOS live in registers; the
// deeper entries live in stack_ram. Push, pop and replace-top each take one
// cycle; all outputs are registered.
//   clk    : clock, rising edge
//   reset  : synchronous active-high clear
//   s      : data_stack_if.slave (push/pop/push_data/clear_err in;
//            tos/nos/count/empty/full/overflow/underflow out)
// Build option: define DATA_STACK_GUARD_EN to suppress push-on-full and
// pop-on-empty and enable the sticky overflow/underflow flags. Without it no
// boundary checks are made, the pointer/count wrap, and both flags read 0.
// -----------------------------------------------------------------------------
module data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    data_stack_if.slave  s
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

`ifdef DATA_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    stack_op_t        op;
    occ_state_t       state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [WIDTH-1:0] tos_q, tos_nxt;
    logic [WIDTH-1:0] nos_q, nos_nxt;
    logic             ovf_q, ovf_nxt;
    logic             udf_q, udf_nxt;
    logic             do_push, do_pop;
    logic             ovf_set, udf_set;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    // With n entries, element k (0 = bottom) sits at array index k for
    // k <= n-3. A push spills NOS to index n-2; a pop refills NOS from n-3.
    assign ram_waddr = AW'(cnt_q - CW'(2));
    assign ram_raddr = AW'(cnt_q - CW'(3));
    assign ram_we    = do_push && (cnt_q >= CW'(2));

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (nos_q),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        op      = stack_op_t'({s.push, s.pop});
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        tos_nxt = tos_q;
        nos_nxt = nos_q;
        cnt_nxt = cnt_q;

        case (op)
            OP_PUSH: begin
                if (GUARD && (state_q == FULL)) ovf_set = 1'b1;
                else                            do_push = 1'b1;
            end
            OP_POP: begin
                if (GUARD && (state_q == EMPTY)) udf_set = 1'b1;
                else                             do_pop  = 1'b1;
            end
            OP_REPL: begin
                // Replacing a non-existent top degrades to a push but is
                // still reported as an underflow.
                if (state_q == EMPTY) begin
                    do_push = 1'b1;
                    udf_set = 1'b1;
                end else begin
                    tos_nxt = s.push_data;
                end
            end
            default: ;
        endcase

        if (do_push) begin
            tos_nxt = s.push_data;
            nos_nxt = tos_q;
            cnt_nxt = cnt_q + CW'(1);
        end
        if (do_pop) begin
            tos_nxt = nos_q;
            nos_nxt = (cnt_q >= CW'(3)) ? ram_rdata : '0;
            cnt_nxt = cnt_q - CW'(1);
        end

        // Occupancy follows the new count so status matches tos/nos.
        if (cnt_nxt == '0)             state_nxt = EMPTY;
        else if (cnt_nxt == CW'(DEPTH)) state_nxt = FULL;
        else                           state_nxt = PARTIAL;

        // A new error in the clearing cycle wins over clear_err.
        ovf_nxt = GUARD ? ((ovf_q & ~s.clear_err) | ovf_set) : 1'b0;
        udf_nxt = GUARD ? ((udf_q & ~s.clear_err) | udf_set) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            tos_q   <= tos_nxt;
            nos_q   <= nos_nxt;
            ovf_q   <= ovf_nxt;
            udf_q   <= udf_nxt;
        end
    end

    assign s.tos       = tos_q;
    assign s.nos       = nos_q;
    assign s.count     = cnt_q;
    assign s.empty     = (state_q == EMPTY);
    assign s.full      = (state_q == FULL);
    assign s.overflow  = ovf_q;
    assign s.underflow = udf_q;

endmodule

// File: tb/tb_data_stack.sv
// -----------------------------------------------------------------------------
// tb_data_stack
// Directed bench for data_stack (WIDTH=16, DEPTH=16). Guard-dependent
// expectations follow DATA_STACK_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_data_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

`ifdef DATA_STACK_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    data_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) s ();

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Apply one operation for one edge, then sample 1 time unit after it.
    task automatic op(input logic p, input logic q, input logic [15:0] d, input logic c);
        s.push = p; s.pop = q; s.push_data = d; s.clear_err = c;
        @(posedge clk); #1;
        s.push = 1'b0; s.pop = 1'b0; s.clear_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s.push = 1'b0; s.pop = 1'b0; s.push_data = '0; s.clear_err = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        op(0, 0, 16'h0, 0);
        checks++; if (s.tos !== 16'h0000) begin errors++; $display("FAIL reset_tos: got %h expected 0000", s.tos); end
        checks++; if (s.nos !== 16'h0000) begin errors++; $display("FAIL reset_nos: got %h expected 0000", s.nos); end
        checks++; if (s.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", s.count); end
        checks++; if (s.empty !== 1'b1 || s.full !== 1'b0) begin errors++; $display("FAIL reset_status: empty %b full %b expected 1 0", s.empty, s.full); end
        checks++; if (s.overflow !== 1'b0 || s.underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: ovf %b udf %b expected 0 0", s.overflow, s.underflow); end
    endtask

    task automatic test_push_pop();
        do_reset();
        op(1, 0, 16'hFF85, 0);
        checks++; if (s.tos !== 16'hFF85 || s.count !== 5'd1 || s.empty !== 1'b0) begin errors++; $display("FAIL push1: tos %h count %0d empty %b expected FF85 1 0", s.tos, s.count, s.empty); end
        op(1, 0, 16'h0012, 0);
        checks++; if (s.tos !== 16'h0012 || s.nos !== 16'hFF85 || s.count !== 5'd2) begin errors++; $display("FAIL push2: tos %h nos %h count %0d expected 0012 FF85 2", s.tos, s.nos, s.count); end
        op(0, 1, 16'h0, 0);
        checks++; if (s.tos !== 16'hFF85 || s.nos !== 16'h0000 || s.count !== 5'd1) begin errors++; $display("FAIL pop1: tos %h nos %h count %0d expected FF85 0000 1", s.tos, s.nos, s.count); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 16; i++) op(1, 0, 16'(i), 0);
        checks++; if (s.full !== 1'b1 || s.tos !== 16'd16 || s.nos !== 16'd15 || s.count !== 5'd16) begin errors++; $display("FAIL fill: full %b tos %0d nos %0d count %0d expected 1 16 15 16", s.full, s.tos, s.nos, s.count); end
        if (G) begin
            op(1, 0, 16'hAAAA, 0);
            checks++; if (s.overflow !== 1'b1 || s.tos !== 16'd16 || s.count !== 5'd16 || s.full !== 1'b1) begin errors++; $display("FAIL push_on_full: ovf %b tos %0d count %0d full %b expected 1 16 16 1", s.overflow, s.tos, s.count, s.full); end
        end
        for (int k = 1; k <= 16; k++) begin
            op(0, 1, 16'h0, 0);
            checks++;
            if (s.tos !== 16'(16 - k) || s.nos !== ((16 - k >= 2) ? 16'(15 - k) : 16'h0) || s.count !== 5'(16 - k)) begin
                errors++;
                $display("FAIL drain_%0d: tos %0d nos %0d count %0d expected %0d %0d %0d", k, s.tos, s.nos, s.count, 16 - k, (16 - k >= 2) ? 15 - k : 0, 16 - k);
            end
        end
        checks++; if (s.empty !== 1'b1 || s.full !== 1'b0) begin errors++; $display("FAIL drain_empty: empty %b full %b expected 1 0", s.empty, s.full); end
    endtask

    task automatic test_underflow();
        do_reset();
        op(0, 1, 16'h0, 0);
        if (G) begin
            checks++; if (s.underflow !== 1'b1 || s.count !== 5'd0 || s.empty !== 1'b1) begin errors++; $display("FAIL pop_on_empty: udf %b count %0d empty %b expected 1 0 1", s.underflow, s.count, s.empty); end
            op(0, 1, 16'h0, 1);
            checks++; if (s.underflow !== 1'b1) begin errors++; $display("FAIL clear_vs_new_err: udf %b expected 1", s.underflow); end
            op(0, 0, 16'h0, 1);
            checks++; if (s.underflow !== 1'b0 || s.overflow !== 1'b0) begin errors++; $display("FAIL clear_err: udf %b ovf %b expected 0 0", s.underflow, s.overflow); end
        end else begin
            checks++; if (s.count !== 5'd31 || s.underflow !== 1'b0 || s.empty !== 1'b0) begin errors++; $display("FAIL pop_wrap: count %0d udf %b empty %b expected 31 0 0", s.count, s.underflow, s.empty); end
        end
    endtask

    task automatic test_replace();
        do_reset();
        op(1, 0, 16'h0002, 0);
        op(1, 0, 16'h0003, 0);
        op(1, 1, 16'h0005, 0);
        checks++; if (s.tos !== 16'h0005 || s.nos !== 16'h0002 || s.count !== 5'd2) begin errors++; $display("FAIL replace: tos %h nos %h count %0d expected 0005 0002 2", s.tos, s.nos, s.count); end
        for (int i = 3; i <= 16; i++) op(1, 0, 16'(i), 0);
        op(1, 1, 16'hBEEF, 0);
        checks++; if (s.tos !== 16'hBEEF || s.nos !== 16'd15 || s.count !== 5'd16 || s.full !== 1'b1) begin errors++; $display("FAIL replace_full: tos %h nos %0d count %0d full %b expected BEEF 15 16 1", s.tos, s.nos, s.count, s.full); end
        checks++; if (s.overflow !== 1'b0 || s.underflow !== 1'b0) begin errors++; $display("FAIL replace_full_flags: ovf %b udf %b expected 0 0", s.overflow, s.underflow); end
        op(0, 1, 16'h0, 0);
        checks++; if (s.tos !== 16'd15 || s.nos !== 16'd14 || s.count !== 5'd15) begin errors++; $display("FAIL pop_after_replace: tos %0d nos %0d count %0d expected 15 14 15", s.tos, s.nos, s.count); end
        do_reset();
        op(1, 1, 16'h0007, 0);
        checks++; if (s.tos !== 16'h0007 || s.nos !== 16'h0000 || s.count !== 5'd1 || s.underflow !== G) begin errors++; $display("FAIL replace_empty: tos %h nos %h count %0d udf %b expected 0007 0000 1 %b", s.tos, s.nos, s.count, s.underflow, G); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        op(1, 0, 16'h0A0A, 0);
        op(1, 0, 16'h0B0B, 0);
        op(1, 0, 16'h0C0C, 0);
        op(0, 1, 16'h0, 0);
        op(1, 0, 16'h0D0D, 0);
        checks++; if (s.tos !== 16'h0D0D || s.nos !== 16'h0B0B || s.count !== 5'd3) begin errors++; $display("FAIL b2b_push: tos %h nos %h count %0d expected 0D0D 0B0B 3", s.tos, s.nos, s.count); end
        op(0, 1, 16'h0, 0);
        op(0, 1, 16'h0, 0);
        checks++; if (s.tos !== 16'h0A0A || s.nos !== 16'h0000 || s.count !== 5'd1) begin errors++; $display("FAIL b2b_pop: tos %h nos %h count %0d expected 0A0A 0000 1", s.tos, s.nos, s.count); end
    endtask

    task automatic test_reset_override();
        do_reset();
        op(1, 0, 16'h1111, 0);
        reset = 1'b1;
        op(1, 0, 16'h1234, 0);
        reset = 1'b0;
        checks++; if (s.count !== 5'd0 || s.tos !== 16'h0000 || s.nos !== 16'h0000 || s.empty !== 1'b1) begin errors++; $display("FAIL reset_override: count %0d tos %h nos %h empty %b expected 0 0000 0000 1", s.count, s.tos, s.nos, s.empty); end
    endtask

    initial begin
        reset = 1'b1;
        s.push = 1'b0; s.pop = 1'b0; s.push_data = '0; s.clear_err = 1'b0;
        test_reset();
        test_push_pop();
        test_fill_drain();
        test_underflow();
        test_replace();
        test_back_to_back();
        test_reset_override();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
